// File: rtl/irq_request_encoder_pkg.sv
// Shared constants, FSM encoding and priority helper for the IRQ request encoder.
package irq_request_encoder_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Index of the highest set bit; all-zero input yields 0.
    function automatic logic [IDX_W-1:0] highest_set(input logic [N-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_request_encoder_sync_edge_detect.sv
// Multi-flop synchroniser for asynchronous request lines followed by a rising-edge pulse.
module sync_edge_detect #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] rise_o
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  prev_q;

    // Synchroniser chain plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= din_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_request_encoder.sv
// Sticky pending IRQ requests, masked priority selection and a valid/ack grant FSM.
module irq_request_encoder
    import irq_request_encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     Din,
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] Dout,
    output logic             valid,
    input  logic             ack,
    output logic [N-1:0]     pending
);

    logic [N-1:0]     rise_s;
    logic [N-1:0]     elig_s;
    logic [N-1:0]     clr_s;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    state_e           state_q, state_d;

    sync_edge_detect #(
        .W           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (Din),
        .rise_o (rise_s)
    );

    assign elig_s = pending_q & ~mask;

    // Grant FSM: pick in IDLE, hold in GRANT until ack or abandon, one-cycle GAP bubble.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        clr_s   = '0;
        case (state_q)
            IDLE: begin
                if (en && (elig_s != '0)) begin
                    dout_d  = highest_set(elig_s);
                    valid_d = 1'b1;
                    state_d = GRANT;
                end else begin
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (ack) begin
                    clr_s[dout_q] = 1'b1;
                    valid_d       = 1'b0;
                    state_d       = GAP;
                end else if (!en) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            GAP: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A fresh edge on the bit being acknowledged re-arms it: set wins over clear.
    assign pending_d = (pending_q & ~clr_s) | rise_s;

    // State, grant and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    assign Dout    = dout_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_request_encoder.sv
// Scoreboard bench: a transaction-level model predicts pending/valid/Dout and grants;
// a negedge monitor pops and compares.
module tb_irq_request_encoder;

    localparam int NB = 8;

    typedef struct packed {
        logic [7:0] p;
        logic       v;
        logic [2:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, en, ack, valid;
    logic [7:0] din, mask, pending;
    logic [2:0] dout;

    irq_request_encoder #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .Din     (din),
        .mask    (mask),
        .Dout    (dout),
        .valid   (valid),
        .ack     (ack),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   gnt_q[$];
    int   obs_q[$];
    int   grant_cnt[NB];
    bit   prev_valid = 1'b0;
    bit   auto_ack   = 1'b0;

    // Reference model state: din history (sync latency), pending bits, grant phase.
    logic [7:0] m_pending, m_h0, m_h1, m_h2;
    logic [2:0] m_dout;
    bit         m_granted, m_bubble;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = '0; m_h0 = '0; m_h1 = '0; m_h2 = '0;
        m_dout = '0; m_granted = 1'b0; m_bubble = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] rise, clr, elig;
        int idx;
        bit found;
        if (!rst_n) begin
            model_reset();
        end else begin
            rise = m_h1 & ~m_h2;
            clr  = '0;
            if (m_granted) begin
                if (ack) begin
                    clr[m_dout] = 1'b1;
                    m_granted = 1'b0;
                    m_bubble  = 1'b1;
                end else if (!en) begin
                    m_granted = 1'b0;
                end
            end else if (m_bubble) begin
                m_bubble = 1'b0;
            end else begin
                elig = m_pending & ~mask;
                found = 1'b0;
                idx = 0;
                for (int i = NB - 1; i >= 0; i--) begin
                    if (elig[i] && !found) begin
                        idx = i;
                        found = 1'b1;
                    end
                end
                if (en && found) begin
                    m_dout    = idx[2:0];
                    m_granted = 1'b1;
                    gnt_q.push_back(idx);
                end
            end
            m_pending = (m_pending & ~clr) | rise;
            m_h2 = m_h1; m_h1 = m_h0; m_h0 = din;
        end
    endtask

    // One clock: predict, let the edge happen, post the expectation, step off the edge.
    task automatic cycle();
        exp_t e;
        if (auto_ack) ack = m_granted;
        model_step();
        @(posedge clk);
        e.p = m_pending; e.v = m_granted; e.d = m_dout;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_obs(input string name, input int pos, input int expv);
        if (pos < obs_q.size()) chk(name, obs_q[pos], expv);
        else chk({name, "_missing"}, 32'hDEAD, expv);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pending", pending, e.p);
            chk("valid", valid, e.v);
            chk("dout", dout, e.d);
        end
        if (valid && !prev_valid) begin
            obs_q.push_back(dout);
            grant_cnt[dout]++;
            if (gnt_q.size() == 0) chk("unexpected_grant", dout, 32'hFFFF);
            else chk("grant_idx", dout, gnt_q.pop_front());
        end
        prev_valid = valid;
    end

    initial begin
        int base, c0;
        for (int i = 0; i < NB; i++) grant_cnt[i] = 0;
        rst_n = 1'b0; en = 1'b0; ack = 1'b0; din = '0; mask = '0;
        model_reset();
        run(3);
        chk("rst_pending", pending, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_dout", dout, 3'd0);
        rst_n = 1'b1;
        run(2);

        // Basic grant with latency checks
        en = 1'b1; auto_ack = 1'b1; din = 8'h04;
        cycle(); din = 8'h00; run(2);
        chk("basic_pending3", pending, 8'h04);
        chk("basic_novalid3", valid, 1'b0);
        cycle();
        chk("basic_valid", valid, 1'b1);
        chk("basic_dout", dout, 3'd2);
        cycle();
        chk("basic_ack_valid", valid, 1'b0);
        chk("basic_ack_pending", pending, 8'h00);
        run(3);

        // Priority: simultaneous bits 7 and 0
        base = obs_q.size();
        din = 8'h81; cycle(); din = 8'h00; run(12);
        chk_obs("prio_first", base, 7);
        chk_obs("prio_second", base + 1, 0);
        chk("prio_pending", pending, 8'h00);

        // Mask and enable
        base = obs_q.size();
        mask = 8'hF0; en = 1'b0; din = 8'h42; cycle(); din = 8'h00; run(6);
        chk("en0_novalid", valid, 1'b0);
        chk("en0_nogrant", obs_q.size(), base);
        en = 1'b1; run(5);
        chk_obs("mask_grant1", base, 1);
        chk("mask_pending6", pending, 8'h40);
        mask = 8'h00; run(5);
        chk_obs("unmask_grant6", base + 1, 6);

        // Frozen grant then abandon
        auto_ack = 1'b0; ack = 1'b0;
        din = 8'h08; cycle(); din = 8'h00; run(5);
        din = 8'h20; cycle(); din = 8'h00; run(5);
        chk("frozen_dout", dout, 3'd3);
        chk("frozen_valid", valid, 1'b1);
        en = 1'b0; cycle();
        chk("abandon_valid", valid, 1'b0);
        chk("abandon_pending", pending, 8'h28);
        base = obs_q.size();
        en = 1'b1; auto_ack = 1'b1; run(10);
        chk_obs("reenable_first", base, 5);
        chk_obs("reenable_second", base + 1, 3);

        // Set/clear collision on bit 4
        c0 = grant_cnt[4];
        auto_ack = 1'b0; ack = 1'b0;
        din = 8'h10; cycle(); din = 8'h00; run(5);
        din = 8'h10; cycle(); din = 8'h00; cycle();
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("collide_pending4", pending[4], 1'b1);
        chk("collide_valid", valid, 1'b0);
        auto_ack = 1'b1; run(8);
        chk("collide_regrant", grant_cnt[4] - c0, 2);

        // Level hold on bit 2
        c0 = grant_cnt[2];
        din = 8'h04; run(20); din = 8'h00; run(6);
        chk("level_once", grant_cnt[2] - c0, 1);

        // Reset mid-grant
        auto_ack = 1'b0; ack = 1'b0;
        din = 8'h40; cycle(); din = 8'h00; run(5);
        chk("midrst_pre_valid", valid, 1'b1);
        chk("midrst_pre_dout", dout, 3'd6);
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        model_reset();
        chk("midrst_valid", valid, 1'b0);
        chk("midrst_dout", dout, 3'd0);
        chk("midrst_pending", pending, 8'h00);
        run(2);
        rst_n = 1'b1;
        base = obs_q.size();
        en = 1'b1; auto_ack = 1'b1; run(10);
        chk("midrst_noreplay", obs_q.size(), base);

        // Randomised traffic
        auto_ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int b;
            if ($urandom_range(3) == 0) begin
                b = $urandom_range(7);
                din[b] = ~din[b];
            end
            if ($urandom_range(19) == 0) mask = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
            en  = ($urandom_range(9) != 0);
            ack = 1'($urandom_range(1));
            cycle();
        end

        @(negedge clk); #1;
        chk("grants_drained", gnt_q.size(), 0);
        chk("expect_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_request_encoder.md
Name: irq_request_encoder

Overview:
- Front-end stage that feeds the priority-encode path. It samples 8 asynchronous request lines, synchronises them and edge-detects them, and holds them as sticky pending bits.
- It applies a mask and presents the index of the highest-priority pending request as a 3-bit code, using a valid/ack handshake.
- It turns raw one-hot-ish events into a stable, one-at-a-time encoded stream for the downstream consumer.

Parameters:
- N, 8, number of request lines.
- IDX_W, 3, width of the encoded index (clog2(N)).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (legal values 2..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  grant enable; when 0, no new grant is issued.
- Din  input  N  raw asynchronous request lines; a rising edge raises a request.
- mask  input  N  1 = line masked; it still pends but is not granted.
- Dout  output  IDX_W  index of the granted request; stable while valid=1.
- valid  output  1  Dout holds a granted request.
- ack  input  1  consumer accepts the current grant.
- pending  output  N  sticky pending register, for status readback.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchroniser flops, edge-history flop, pending, Dout and valid all go to 0.
  - FSM goes to IDLE.
  - A reset asserted mid-grant drops the grant immediately, and the grant is not replayed.
- Synchroniser: each Din bit passes through SYNC_STAGES flops. An edge register holds the previous synced value. rise = synced & ~prev.
- Pending:
  - pending[i] sets on rise[i].
  - pending[i] clears when ack is accepted for Dout==i.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
- Latency: a Din rising edge becomes visible in pending SYNC_STAGES+1 cycles after the first clk edge that samples it high. Valid can assert the cycle after that.
- Eligibility:
  - elig = pending & ~mask.
  - Highest index wins, so bit 7 has top priority, matching the downstream encoder's convention.
- FSM states IDLE, GRANT, GAP:
  - IDLE: if en=1 and elig!=0, register Dout = index of the highest set bit of elig, set valid=1, go to GRANT. Otherwise stay with valid=0.
  - GRANT:
    - valid=1 and Dout frozen, even if higher-priority requests arrive or mask changes.
    - If ack=1: clear pending[Dout], set valid=0, go to GAP.
    - Else if en=0: set valid=0, keep pending unchanged, go to IDLE (abandoned grant).
    - If ack and en=0 occur in the same cycle, ack takes effect.
  - GAP: valid=0 for exactly one cycle, then IDLE. This guarantees a one-cycle bubble between back-to-back grants.
- ack outside GRANT is ignored and has no effect on pending.
- A level held high on Din produces exactly one request. A new request needs the line to go low and then high again.
- Dout keeps its last value while valid=0. The consumer must qualify Dout with valid.
- Back-to-back throughput: at most one grant per 3 cycles (IDLE→GRANT, ack, GAP).

Decomposition:
- Shared package holds:
  - localparams N and IDX_W;
  - FSM state encoding IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - a function for the highest-set-bit index, returning IDX_W bits and 0 for all-zero input.
- One natural sub-module, sync_edge_detect: the SYNC_STAGES synchroniser plus rising-edge pulse, width N.
- Pending, priority select and FSM stay in the top module.

Test Plan:
- Reset and basic grant:
  - Stimulus: rst_n low then high; Din=8'b00000100, en=1, mask=0; ack on the first valid cycle.
  - Response: pending=8'h04 after 3 clk; valid=1 with Dout=3'd2 on the next cycle; the cycle after ack gives pending=0 and valid=0.
- Priority:
  - Stimulus: pulse Din=8'b10000001 simultaneously; ack each grant.
  - Response: first grant Dout=3'd7, then one GAP cycle with valid=0, then Dout=3'd0, then pending=0.
- Mask and enable:
  - Stimulus: mask=8'hF0, Din edge on bit 6; en=0 with Din edge on bit 1.
  - Response: no valid while en=0; with en=1, Dout=3'd1 is granted while bit 6 stays pending. Clearing mask then grants Dout=3'd6.
- Frozen grant and abandon:
  - Stimulus: grant on bit 3 with no ack; raise a bit-5 edge; then drop en.
  - Response: Dout stays 3'd3 while valid=1; dropping en clears valid and leaves pending=8'h28. Re-enabling grants 3'd5 first.
- Set/clear collision and level hold:
  - Stimulus: ack grant of bit 4 in the same cycle a new bit-4 edge arrives; hold Din[2] high for 20 cycles.
  - Response: pending[4] remains 1 and is re-granted; bit 2 is granted exactly once.
- Reset mid-grant:
  - Stimulus: rst_n asserted while valid=1 with Dout=3'd6.
  - Response: valid, Dout and pending go to 0 immediately, with no grant after release.
